// File: rtl/gol_next_gen_if.sv
// Row-file and control bundle between the Game of Life generation engine and its environment.
// The 'stable' signal exists only when GOL_STABLE_DETECT_EN is defined.
interface gol_next_gen_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
);
  logic               start;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic [WIDTH-1:0]   rd3;
  logic [REGBITS-1:0] ra;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic               regwrite;
  logic               busy;
  logic               done;
  logic [GENBITS-1:0] gen_count;
`ifdef GOL_STABLE_DETECT_EN
  logic               stable;
`endif

  modport master (
    input  start, rd1, rd2, rd3,
    output ra, wa, wd, regwrite, busy, done, gen_count
`ifdef GOL_STABLE_DETECT_EN
    , output stable
`endif
  );

  modport slave (
    output start, rd1, rd2, rd3,
    input  ra, wa, wd, regwrite, busy, done, gen_count
`ifdef GOL_STABLE_DETECT_EN
    , input stable
`endif
  );
endinterface

// File: rtl/gol_next_gen.sv
// Game of Life generation engine: sweeps the row file, buffers every next row, then commits them.
// Optional GOL_STABLE_DETECT_EN skips the commit and raises 'stable' when no row changed.
module gol_next_gen #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic           ph1,
  input  logic           reset,
  gol_next_gen_if.master bus
);
  localparam int ROWS = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] FIRST_ROW = REGBITS'(1);
  localparam logic [REGBITS-1:0] LAST_ROW  = REGBITS'(ROWS - 1);

  // IDLE wait for start | SWEEP read+compute one row/cycle | COMMIT write one row/cycle | DONE pulse done
  typedef enum logic [1:0] {IDLE, SWEEP, COMMIT, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [REGBITS-1:0] r_row, w_row_nxt;
  logic [WIDTH-1:0]   r_buf [ROWS];
  logic [REGBITS-1:0] r_wa;
  logic [WIDTH-1:0]   r_wd;
  logic               r_regwrite;
  logic               r_done;
  logic [GENBITS-1:0] r_gen;
  logic [WIDTH+1:0]   w_up, w_mid, w_dn;
  logic [WIDTH-1:0]   w_next_row;
  logic [3:0]         w_n;

  // One dead pad column on each side removes horizontal wrap and edge special cases.
  assign w_up  = {1'b0, bus.rd1, 1'b0};
  assign w_mid = {1'b0, bus.rd2, 1'b0};
  assign w_dn  = {1'b0, bus.rd3, 1'b0};

  always_comb begin
    w_next_row = '0;
    w_n        = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_n = 4'(w_up[c]) + 4'(w_up[c+1]) + 4'(w_up[c+2]) +
            4'(w_mid[c]) + 4'(w_mid[c+2]) +
            4'(w_dn[c]) + 4'(w_dn[c+1]) + 4'(w_dn[c+2]);
      w_next_row[c] = (w_n == 4'd3) | (w_mid[c+1] & (w_n == 4'd2));
    end
  end

`ifdef GOL_STABLE_DETECT_EN
  logic r_diff, r_stable, w_changed;

  assign w_changed  = r_diff | (w_next_row != bus.rd2);
  assign bus.stable = r_stable;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_diff   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      if (r_state == IDLE)       r_diff <= 1'b0;
      else if (r_state == SWEEP) r_diff <= w_changed;
      if (r_state == DONE)       r_stable <= ~r_diff;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SWEEP;
          w_row_nxt   = FIRST_ROW;
        end
      end
      SWEEP: begin
        if (r_row == LAST_ROW) begin
          w_state_nxt = COMMIT;
          w_row_nxt   = FIRST_ROW;
`ifdef GOL_STABLE_DETECT_EN
          if (!w_changed) w_state_nxt = DONE;
`endif
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end
      COMMIT: begin
        if (r_row == LAST_ROW) w_state_nxt = DONE;
        else                   w_row_nxt   = r_row + 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_gen      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_regwrite <= (w_state_nxt == COMMIT);
      r_done     <= (w_state_nxt == DONE);
      if (w_state_nxt == COMMIT) begin
        r_wa <= w_row_nxt;
        r_wd <= r_buf[w_row_nxt];
      end
      if (r_state == DONE) r_gen <= r_gen + 1'b1;
    end
  end

  // Row buffer needs no reset: every entry is rewritten by the sweep before it is committed.
  always_ff @(posedge ph1) begin
    if (r_state == SWEEP) r_buf[r_row] <= w_next_row;
  end

  assign bus.ra        = (r_state == SWEEP) ? r_row : '0;
  assign bus.wa        = r_wa;
  assign bus.wd        = r_wd;
  assign bus.regwrite  = r_regwrite;
  assign bus.busy      = (r_state == SWEEP) || (r_state == COMMIT);
  assign bus.done      = r_done;
  assign bus.gen_count = r_gen;
endmodule

// File: tb/tb_gol_next_gen.sv
// Bench for gol_next_gen: row-file model, whole-field Life model checked every cycle, directed scenarios.
// Uses a narrow generation counter so counter wrap is reachable in a short run.
module tb_gol_next_gen;
  localparam int W    = 8;
  localparam int RB   = 3;
  localparam int GB   = 4;
  localparam int ROWS = 8;
`ifdef GOL_STABLE_DETECT_EN
  localparam bit STABLE_EN = 1'b1;
`else
  localparam bit STABLE_EN = 1'b0;
`endif

  typedef logic [ROWS-1:0][W-1:0] grid_t;

  logic  ph1 = 1'b0;
  logic  reset = 1'b1;
  grid_t mem = '0;
  grid_t ld_grid = '0;
  logic  ld_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  gol_next_gen_if #(.WIDTH(W), .REGBITS(RB), .GENBITS(GB)) bus ();

  gol_next_gen #(.WIDTH(W), .REGBITS(RB), .GENBITS(GB)) dut (
    .ph1  (ph1),
    .reset(reset),
    .bus  (bus)
  );

  always #5 ph1 = ~ph1;

  // Register file: row 0 is hardwired zero, neighbours outside the field read as zero.
  assign bus.rd1 = (bus.ra == 3'd0) ? '0 : mem[bus.ra - 3'd1];
  assign bus.rd2 = mem[bus.ra];
  assign bus.rd3 = (bus.ra == 3'd7) ? '0 : mem[bus.ra + 3'd1];

  always @(posedge ph1) begin
    if (ld_en)             mem <= ld_grid;
    else if (bus.regwrite) mem[bus.wa] <= bus.wd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic grid_t life(input grid_t g);
    grid_t r;
    int n, yy, xx;
    r = '0;
    for (int y = 1; y < ROWS; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if (!(dy == 0 && dx == 0) && yy >= 1 && yy < ROWS && xx >= 0 && xx < W)
              n += int'(g[yy][xx]);
          end
        end
        r[y][x] = (n == 3) || (g[y][x] && n == 2);
      end
    end
    return r;
  endfunction

  // Cycle-level model: k counts cycles since the accepted start (0 = idle).
  grid_t           m_grid = '0;
  grid_t           m_new = '0;
  logic            m_same = 1'b0;
  int              m_k = 0;
  int              m_done_k = 15;
  logic [GB-1:0]   m_gen = '0;
  logic [RB-1:0]   m_wa = '0;
  logic [W-1:0]    m_wd = '0;
`ifdef GOL_STABLE_DETECT_EN
  logic            m_stable = 1'b0;
`endif

  always @(negedge ph1) begin
    logic e_busy, e_we, e_done;
    logic [RB-1:0] e_ra;
    if (reset) begin
      m_k = 0; m_gen = '0; m_wa = '0; m_wd = '0;
`ifdef GOL_STABLE_DETECT_EN
      m_stable = 1'b0;
      chk("rst_stable", bus.stable, 0);
`endif
      chk("rst_ra", bus.ra, 0);
      chk("rst_wa", bus.wa, 0);
      chk("rst_wd", bus.wd, 0);
      chk("rst_regwrite", bus.regwrite, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_gen", bus.gen_count, 0);
    end else begin
      if (ld_en) m_grid = ld_grid;
      e_busy = (m_k >= 1) && (m_k < m_done_k);
      e_ra   = (m_k >= 1 && m_k <= 7) ? RB'(m_k) : '0;
      e_we   = (m_k >= 8) && (m_k < m_done_k);
      e_done = (m_k != 0) && (m_k == m_done_k);
      if (e_we) begin
        m_wa = RB'(m_k - 7);
        m_wd = m_new[m_k - 7];
      end
      chk("busy", bus.busy, e_busy);
      chk("ra", bus.ra, e_ra);
      chk("regwrite", bus.regwrite, e_we);
      chk("wa", bus.wa, m_wa);
      chk("wd", bus.wd, m_wd);
      chk("done", bus.done, e_done);
      chk("gen_count", bus.gen_count, m_gen);
`ifdef GOL_STABLE_DETECT_EN
      chk("stable", bus.stable, m_stable);
`endif
      if (m_k == 0 && !ld_en) chk("field", mem, m_grid);
      if (m_k == 0) begin
        if (bus.start) begin
          m_new    = life(m_grid);
          m_same   = (m_new == m_grid);
          m_done_k = (STABLE_EN && m_same) ? 8 : 15;
          m_k      = 1;
        end
      end else if (m_k == m_done_k) begin
        m_k    = 0;
        m_gen  = m_gen + 1'b1;
        m_grid = m_new;
`ifdef GOL_STABLE_DETECT_EN
        m_stable = m_same;
`endif
      end else begin
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic load(input grid_t g);
    ld_grid = g;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((bus.busy || bus.done) && guard < 40) begin
      tick();
      guard++;
    end
    chk("idle_timeout", bus.busy | bus.done, 0);
  endtask

  task automatic step(output int cyc);
    wait_idle();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("done_timeout", bus.done, 1);
    tick();
  endtask

  grid_t blinker, block_g, edge_g;
  int    cyc, ndone;
  logic [GB-1:0] g0;

  initial begin
    bus.start = 1'b0;
    blinker = '0; blinker[2] = 8'b00010000; blinker[3] = 8'b00010000; blinker[4] = 8'b00010000;
    block_g = '0; block_g[1] = 8'b11000000; block_g[2] = 8'b11000000;
    edge_g  = '0; edge_g[7] = 8'b00000001; edge_g[1] = 8'b11000000; edge_g[2] = 8'b10000000;

    repeat (3) tick();
    chk("reset_gen", bus.gen_count, 0);
    chk("reset_regwrite", bus.regwrite, 0);
    reset = 1'b0;
    tick();

    // Vertical blinker: two steps return to the original pattern.
    load(blinker);
    step(cyc);
    chk("blinker_latency", cyc, 15);
    chk("blinker_row2", mem[2], 8'b00000000);
    chk("blinker_row3", mem[3], 8'b00111000);
    chk("blinker_row4", mem[4], 8'b00000000);
    chk("blinker_gen1", bus.gen_count, 1);
    step(cyc);
    chk("blinker_back", mem, blinker);
    chk("blinker_gen2", bus.gen_count, 2);

    // Reset mid-sweep takes effect in the same cycle.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_regwrite", bus.regwrite, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ra", bus.ra, 0);
    chk("midrst_gen", bus.gen_count, 0);
    tick();
    reset = 1'b0;
    tick();
    step(cyc);
    chk("after_rst_latency", cyc, 15);
    chk("after_rst_row3", mem[3], 8'b00111000);
    chk("after_rst_gen", bus.gen_count, 1);

    // Still life.
    load(block_g);
    step(cyc);
    chk("block_latency", cyc, STABLE_EN ? 8 : 15);
    chk("block_same", mem, block_g);
`ifdef GOL_STABLE_DETECT_EN
    chk("block_stable", bus.stable, 1);
`endif

    // Edges: no wrap, lone cell dies, corner L becomes a block.
    load(edge_g);
    step(cyc);
    chk("edge_row1", mem[1], 8'b11000000);
    chk("edge_row2", mem[2], 8'b11000000);
    chk("edge_row7", mem[7], 8'b00000000);
    chk("edge_row3", mem[3], 8'b00000000);

    // start pulses while busy are ignored.
    load(blinker);
    g0 = bus.gen_count;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      bus.start = (i == 3 || i == 10);
      if (bus.done) ndone++;
      tick();
    end
    bus.start = 1'b0;
    chk("ignore_start_dones", ndone, 1);
    chk("ignore_start_gen", bus.gen_count, 4'(g0 + 1'b1));

    // start held high restarts immediately from IDLE.
    bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    bus.start = 1'b0;
    chk("held_start_dones", ndone, 2);
    wait_idle();

    // Generation counter wrap.
    load('0);
    for (int i = 0; i < 20 && bus.gen_count != 4'hF; i++) step(cyc);
    chk("gen_max", bus.gen_count, 4'hF);
    step(cyc);
    chk("gen_wrap_done_latency", cyc, STABLE_EN ? 8 : 15);
    chk("gen_wrap", bus.gen_count, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
